// File: rtl/psum_accumulator_if.sv
// Psum input and result output handshake bundle for psum_accumulator.
// The slave modport is the accumulator; the master modport is the producer/consumer side.
interface psum_accumulator_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  psum_0;
  logic [7:0]  psum_1;
  logic [7:0]  psum_2;
  logic [7:0]  psum_3;

  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_0;
  logic [7:0]  out_1;
  logic [7:0]  out_2;
  logic [7:0]  out_3;
  logic [15:0] out_pix;
  logic [10:0] out_och;

  modport slave (
    input  in_valid, psum_0, psum_1, psum_2, psum_3, out_ready,
    output in_ready, out_valid, out_0, out_1, out_2, out_3, out_pix, out_och
  );

  modport master (
    output in_valid, psum_0, psum_1, psum_2, psum_3, out_ready,
    input  in_ready, out_valid, out_0, out_1, out_2, out_3, out_pix, out_och
  );
endinterface

// File: rtl/psum_accumulator.sv
// Four-lane partial-sum accumulator over input-channel groups with activation output stage.
// Build macro PSUM_RELU_EN selects ReLU+clip activation; otherwise signed 8-bit saturation.
module psum_accumulator #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned ACC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_signal,
  input  logic [15:0]          WxW_out,
  input  logic [11:0]          channel_input_img,
  input  logic [10:0]          no_channel_out,
  output logic                 busy,
  output logic                 done,
  psum_accumulator_if.slave    bus
);

  localparam int unsigned LANES = 4;
  localparam int unsigned PIX_W = 16;
  localparam int unsigned GRP_W = 12;
  localparam int unsigned OCH_W = 11;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                         state_q;
  logic [PIX_W-1:0]               p_q;
  logic [GRP_W-1:0]               c_q;
  logic [OCH_W-1:0]               n_q;
  logic [PIX_W-1:0]               pix_q;
  logic [GRP_W-1:0]               grp_q;
  logic [OCH_W-1:0]               och_q;
  logic                           drain_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           out_valid_q;
  logic [LANES-1:0][OUT_W-1:0]    out_q;
  logic [PIX_W-1:0]               out_pix_q;
  logic [OCH_W-1:0]               out_och_q;

  // Accumulator storage is never reset; every pixel is overwritten by its grp=0 beat.
  logic [LANES-1:0][ACC_W-1:0]    acc_q [DEPTH];

  logic [LANES-1:0][OUT_W-1:0]    psum_c;
  logic [LANES-1:0][ACC_W-1:0]    acc_rd_c;
  logic [LANES-1:0][ACC_W-1:0]    sum_c;
  logic [LANES-1:0][OUT_W-1:0]    act_c;
  logic                           last_pix_c;
  logic                           last_grp_c;
  logic                           last_och_c;
  logic                           in_ready_c;
  logic                           beat_c;
  logic                           final_beat_c;
  logic                           cfg_ok_c;

  function automatic logic [OUT_W-1:0] activate(input logic [ACC_W-1:0] x);
    logic signed [ACC_W-1:0] xs;
    xs = $signed(x);
`ifdef PSUM_RELU_EN
    if (xs[ACC_W-1])      activate = '0;
    else if (xs > SAT_HI) activate = OUT_W'(127);
    else                  activate = xs[OUT_W-1:0];
`else
    if (xs > SAT_HI)      activate = OUT_W'(127);
    else if (xs < SAT_LO) activate = OUT_W'(128);
    else                  activate = xs[OUT_W-1:0];
`endif
  endfunction

  assign psum_c     = {bus.psum_3, bus.psum_2, bus.psum_1, bus.psum_0};
  assign acc_rd_c   = acc_q[pix_q[AW-1:0]];

  assign last_pix_c = (pix_q == p_q - PIX_W'(1));
  assign last_grp_c = (grp_q == c_q - GRP_W'(1));
  assign last_och_c = (och_q == n_q - OCH_W'(1));

  assign cfg_ok_c   = (WxW_out != '0) && (channel_input_img != '0) &&
                      (no_channel_out != '0) && (32'(WxW_out) <= DEPTH);

  // Only the final group beat needs the output register; drain blocks beats past the job end.
  assign in_ready_c   = (state_q == RUN) && !drain_q &&
                        (!last_grp_c || !out_valid_q || bus.out_ready);
  assign beat_c       = bus.in_valid && in_ready_c;
  assign final_beat_c = beat_c && last_pix_c && last_grp_c && last_och_c;

  // First group overwrites, later groups add; both wrap at ACC_W bits.
  always_comb begin
    sum_c = '0;
    act_c = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      sum_c[l] = ((grp_q == '0) ? '0 : acc_rd_c[l]) + ACC_W'($signed(psum_c[l]));
      act_c[l] = activate(sum_c[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (beat_c) begin
      acc_q[pix_q[AW-1:0]] <= sum_c;
    end
  end

  // Control FSM, counters, config latch and registered result stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      p_q         <= '0;
      c_q         <= '0;
      n_q         <= '0;
      pix_q       <= '0;
      grp_q       <= '0;
      och_q       <= '0;
      drain_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_pix_q   <= '0;
      out_och_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (init_signal) begin
            if (cfg_ok_c) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              p_q     <= WxW_out;
              c_q     <= channel_input_img;
              n_q     <= no_channel_out;
              pix_q   <= '0;
              grp_q   <= '0;
              och_q   <= '0;
              drain_q <= 1'b0;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (beat_c) begin
            if (last_grp_c) begin
              out_valid_q <= 1'b1;
              out_q       <= act_c;
              out_pix_q   <= pix_q;
              out_och_q   <= och_q;
            end
            if (last_pix_c) begin
              pix_q <= '0;
              if (last_grp_c) begin
                grp_q <= '0;
                och_q <= last_och_c ? '0 : och_q + OCH_W'(1);
              end else begin
                grp_q <= grp_q + GRP_W'(1);
              end
            end else begin
              pix_q <= pix_q + PIX_W'(1);
            end
            if (final_beat_c) begin
              drain_q <= 1'b1;
            end
          end
          // Finish only once the last result has left the output register.
          if (drain_q && out_valid_q && bus.out_ready) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            drain_q <= 1'b0;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_0     = out_q[0];
  assign bus.out_1     = out_q[1];
  assign bus.out_2     = out_q[2];
  assign bus.out_3     = out_q[3];
  assign bus.out_pix   = out_pix_q;
  assign bus.out_och   = out_och_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameter DEPTH, default 256: maximum output pixels per output-channel group (WxW_out limit).
REQ-002 Parameter ACC_W, default 16: accumulator width per lane, in bits.
REQ-003 Port clk  input  1: single clock; all logic on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-low.
REQ-005 Port init_signal  input  1: single-cycle start pulse.
REQ-006 Port WxW_out  input  16: output pixels per output-channel group.
REQ-007 Port channel_input_img  input  12: input channel groups (1/4 of input channels).
REQ-008 Port no_channel_out  input  11: output channel groups (1/4 of output channels).
REQ-009 Port in_valid  input  1 / in_ready  output  1: psum handshake.
REQ-010 Ports psum_0..psum_3  input  8 each: signed two's-complement partial sums, one lane per output channel.
REQ-011 Port out_valid  output  1 / out_ready  input  1: result handshake.
REQ-012 Ports out_0..out_3  output  8 each: final activations.
REQ-013 Port out_pix  output  16 / out_och  output  11: pixel index and output-channel group of the current result.
REQ-014 Port busy  output  1 / done  output  1: running flag; single-cycle completion pulse.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 IDLE -> RUN SHALL occur on init_signal=1 when all three config values are non-zero and WxW_out<=DEPTH; config SHALL be latched on that edge.
REQ-017 If init_signal=1 with any config value zero or WxW_out>DEPTH, the FSM SHALL go IDLE -> DONE with no output.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 init_signal SHALL be ignored in RUN and DONE.
REQ-020 Input order in RUN: for each och 0..N-1, for each grp 0..C-1, for each pix 0..P-1, one beat per handshake (in_valid&in_ready).
REQ-021 Beat with grp=0: acc[pix][lane] SHALL be written with sign-extended psum_lane.
REQ-022 Beat with grp>0: acc[pix][lane] SHALL be written with acc[pix][lane] + sign-extended psum_lane, wrapping modulo 2^ACC_W.
REQ-023 Beat with grp=C-1 SHALL load the output register with activate(acc + psum) at the next edge, set out_valid, and set out_pix=pix, out_och=och; latency is exactly 1 cycle from beat to out_valid.
REQ-024 When C=1, the grp=0 beat SHALL also be the final beat.
REQ-025 in_ready SHALL be 0 outside RUN.
REQ-026 In RUN, in_ready SHALL be 1 when grp<C-1, or when out_valid=0, or when out_ready=1 (single-entry skid, no bubble).
REQ-027 out_valid SHALL hold, with out_* stable, until out_ready=1.
REQ-028 Counters SHALL advance pix->grp->och, each wrapping to 0 at its limit.
REQ-029 The final beat of the final och SHALL enter DONE only after the last result is accepted (out_valid&out_ready), or in the same cycle if the result is accepted immediately.
REQ-030 busy SHALL be 1 exactly in RUN.

Reset
REQ-031 rst=0 at any clock edge, including mid-RUN, SHALL force IDLE and clear all counters.
REQ-032 rst=0 SHALL clear out_valid, done, busy, out_0..3, out_pix, and out_och to 0.
REQ-033 rst SHALL NOT clear accumulator contents; they are undefined until written.

Configuration
REQ-034 Macro PSUM_RELU_EN defined: activate(x) SHALL output 0 for x<0 and min(x,127) otherwise.
REQ-035 Macro PSUM_RELU_EN undefined: activate(x) SHALL saturate x to the signed range [-128,127], with no ReLU.

Verification
REQ-036 P=4, C=2, N=2, psum_all=3 every beat, out_ready=1 -> 8 results, all lanes 6, out_pix 0..3 per och, then done pulse 1 cycle after last result.
REQ-037 P=4, C=1, N=1, psum_0=-5, psum_1=100, out_ready=1 -> with PSUM_RELU_EN: out_0=0, out_1=100; without: out_0=-5 (0xFB), out_1=100.
REQ-038 P=1, C=3, N=1, psum_0=100 three times -> with PSUM_RELU_EN: out_0=127 (acc 300 saturated); without: out_0=127.
REQ-039 P=4, C=1, N=1, out_ready=0 for 5 cycles after first result -> out_0..3 and out_pix=0 held stable, in_ready=0 while held, no beat lost, 4 results total.
REQ-040 init_signal with WxW_out=0 -> done=1 on the next cycle, out_valid never asserted; init_signal with WxW_out=DEPTH+1 -> same response.
REQ-041 rst=0 after 3 beats of a C=2 run -> next cycle state IDLE, busy=0, out_valid=0; a new init then yields correct results for a full run.
